// File: rtl/pc_next_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pc_next_unit
//  Purpose  : Next-PC generation for the fetch stage. Holds the fetch address,
//             advances it sequentially on accepted fetches, and loads the
//             branch target (branch_pc + branch_off_sh) on taken resolutions.
//             Keeps a saturating count of taken redirects.
//  Options  : PC_ALIGN_CHECK_EN - when defined, a taken branch whose target is
//             not 4-byte aligned is refused, sets the sticky misalign flag and
//             parks the unit in HALT until reset.
//  Revision : 1.0 - initial release
// ============================================================================
module pc_next_unit #(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int          INSTR_BYTES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        branch_valid,
  input  logic        branch_taken,
  input  logic [63:0] branch_pc,
  input  logic [63:0] branch_off_sh,
  input  logic        fetch_ready,
  input  logic        stall,
  output logic [63:0] pc,
  output logic        pc_valid,
  output logic        redirect,
  output logic [31:0] taken_cnt,
  output logic        misalign
);

  localparam logic [1:0]  c_S_BOOT  = 2'd0;
  localparam logic [1:0]  c_S_RUN   = 2'd1;
  localparam logic [1:0]  c_S_HALT  = 2'd2;
  localparam logic [63:0] c_INC     = 64'(INSTR_BYTES);
  localparam logic [31:0] c_CNT_MAX = 32'hFFFF_FFFF;

  logic [1:0]  r_state;
  logic [63:0] r_pc;
  logic        r_redirect;
  logic [31:0] r_taken_cnt;

  logic [63:0] w_target;
  logic        w_run;
  logic        w_redir_evt;
  logic        w_accept;
  logic        w_misal;
  logic        w_load;

  // Branch target and event decode; carry out of the 64-bit add is dropped.
  assign w_target    = branch_pc + branch_off_sh;
  assign w_run       = (r_state == c_S_RUN);
  assign w_redir_evt = w_run & branch_valid & branch_taken;
  assign w_accept    = w_run & fetch_ready & ~stall;

`ifdef PC_ALIGN_CHECK_EN
  logic r_misalign;

  assign w_misal = w_redir_evt & (w_target[1:0] != 2'b00);

  // Sticky misaligned-target flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_misalign <= 1'b0;
    end else if (w_misal) begin
      r_misalign <= 1'b1;
    end
  end

  assign misalign = r_misalign;
`else
  assign w_misal  = 1'b0;
  assign misalign = 1'b0;
`endif

  // A redirect only loads the target when it passes the alignment check.
  assign w_load = w_redir_evt & ~w_misal;

  // State, PC, redirect pulse and taken counter; redirect beats accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= c_S_BOOT;
      r_pc        <= RESET_PC;
      r_redirect  <= 1'b0;
      r_taken_cnt <= 32'd0;
    end else begin
      r_redirect <= w_load;
      case (r_state)
        c_S_BOOT: r_state <= c_S_RUN;
        c_S_RUN: begin
          if (w_misal) begin
            r_state <= c_S_HALT;
          end
          if (w_load) begin
            r_pc <= w_target;
          end else if (w_accept) begin
            r_pc <= r_pc + c_INC;
          end
          if (w_load && (r_taken_cnt != c_CNT_MAX)) begin
            r_taken_cnt <= r_taken_cnt + 32'd1;
          end
        end
        c_S_HALT: r_state <= c_S_HALT;
        default:  r_state <= c_S_BOOT;
      endcase
    end
  end

  assign pc        = r_pc;
  assign pc_valid  = w_run;
  assign redirect  = r_redirect;
  assign taken_cnt = r_taken_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pc_next_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_next_unit
//  Purpose  : Directed and random stimulus for pc_next_unit, compared every
//             cycle against a behavioural model of the fetch-PC rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pc_next_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        branch_valid;
  logic        branch_taken;
  logic [63:0] branch_pc;
  logic [63:0] branch_off_sh;
  logic        fetch_ready;
  logic        stall;
  logic [63:0] pc;
  logic        pc_valid;
  logic        redirect;
  logic [31:0] taken_cnt;
  logic        misalign;

  int tests = 0;
  int fails = 0;

  // Behavioural model of the observable state.
  logic [63:0] m_pc;
  logic        m_valid;
  logic        m_booting;
  logic        m_halted;
  logic        m_red;
  logic [31:0] m_cnt;
  logic        m_mis;

`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  pc_next_unit #(.RESET_PC(64'h0), .INSTR_BYTES(4)) dut (
    .clk(clk), .rst_n(rst_n), .branch_valid(branch_valid),
    .branch_taken(branch_taken), .branch_pc(branch_pc),
    .branch_off_sh(branch_off_sh), .fetch_ready(fetch_ready),
    .stall(stall), .pc(pc), .pc_valid(pc_valid), .redirect(redirect),
    .taken_cnt(taken_cnt), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    logic [63:0] tgt;
    tgt = branch_pc + branch_off_sh;
    if (!rst_n) begin
      m_pc = 64'h0; m_valid = 1'b0; m_booting = 1'b1; m_halted = 1'b0;
      m_red = 1'b0; m_cnt = 32'd0; m_mis = 1'b0;
    end else if (m_booting) begin
      m_booting = 1'b0; m_valid = 1'b1; m_red = 1'b0;
    end else if (m_halted) begin
      m_red = 1'b0;
    end else if (branch_valid && branch_taken) begin
      if (ALIGN_EN && (tgt % 4 != 0)) begin
        m_halted = 1'b1; m_valid = 1'b0; m_mis = 1'b1; m_red = 1'b0;
      end else begin
        m_pc = tgt; m_red = 1'b1;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      end
    end else begin
      m_red = 1'b0;
      if (fetch_ready && !stall) m_pc = m_pc + 4;
    end
  endtask

  // One clock: update model, then compare every output just after the edge.
  task automatic cyc(input string tag);
    model_step();
    @(posedge clk);
    #1;
    chk({tag, ".pc"},       pc,                m_pc);
    chk({tag, ".valid"},    64'(pc_valid),     64'(m_valid));
    chk({tag, ".redirect"}, 64'(redirect),     64'(m_red));
    chk({tag, ".cnt"},      64'(taken_cnt),    64'(m_cnt));
    chk({tag, ".misalign"}, 64'(misalign),     64'(m_mis));
  endtask

  task automatic br(input logic v, input logic t, input logic [63:0] bp, input logic [63:0] off);
    branch_valid = v; branch_taken = t; branch_pc = bp; branch_off_sh = off;
  endtask

  initial begin
    rst_n = 1'b0; fetch_ready = 1'b1; stall = 1'b0;
    br(1'b0, 1'b0, 64'h0, 64'h0);
    m_pc = 64'h0; m_valid = 1'b0; m_booting = 1'b1; m_halted = 1'b0;
    m_red = 1'b0; m_cnt = 32'd0; m_mis = 1'b0;

    // Reset state
    cyc("rst0"); cyc("rst1");
    chk("rst_pc", pc, 64'h0);
    chk("rst_valid", 64'(pc_valid), 64'h0);
    chk("rst_cnt", 64'(taken_cnt), 64'h0);

    // Sequential fetch: BOOT for one cycle, then 0,4,8
    rst_n = 1'b1;
    cyc("boot"); chk("seq0", pc, 64'h0); chk("seq0_valid", 64'(pc_valid), 64'h1);
    cyc("seq");  chk("seq4", pc, 64'h4);
    cyc("seq");  chk("seq8", pc, 64'h8);

    // Backpressure holds at 8, then advances to 12; stall holds too
    fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin cyc("bp"); chk("bp_hold8", pc, 64'h8); end
    fetch_ready = 1'b1;
    cyc("bp_rel"); chk("bp_12", pc, 64'hC);
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin cyc("stall"); chk("stall_hold", pc, 64'hC); end
    stall = 1'b0;

    // Taken branch with a simultaneous accept
    br(1'b1, 1'b1, 64'h100, 64'h40);
    cyc("tkn"); chk("tkn_pc", pc, 64'h140); chk("tkn_red", 64'(redirect), 64'h1);
    chk("tkn_cnt", 64'(taken_cnt), 64'h1);
    br(1'b0, 1'b0, 64'h0, 64'h0);
    cyc("tkn_after"); chk("tkn_red_drop", 64'(redirect), 64'h0); chk("tkn_seq", pc, 64'h144);

    // Backward branch, then not-taken resolution
    br(1'b1, 1'b1, 64'h200, 64'hFFFF_FFFF_FFFF_FFF0);
    cyc("back"); chk("back_pc", pc, 64'h1F0);
    br(1'b1, 1'b0, 64'h500, 64'h80);
    cyc("ntkn"); chk("ntkn_pc", pc, 64'h1F4); chk("ntkn_cnt", 64'(taken_cnt), 64'h2);

    // Wrap-around of the sequential increment
    br(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 64'hC);
    cyc("wrap_ld"); chk("wrap_top", pc, 64'hFFFF_FFFF_FFFF_FFFC);
    br(1'b0, 1'b0, 64'h0, 64'h0);
    cyc("wrap"); chk("wrap_zero", pc, 64'h0);

    // Back-to-back redirects, each with its own target
    br(1'b1, 1'b1, 64'h1000, 64'h0);
    cyc("b2b0"); chk("b2b0_pc", pc, 64'h1000);
    br(1'b1, 1'b1, 64'h2000, 64'h20);
    cyc("b2b1"); chk("b2b1_pc", pc, 64'h2020); chk("b2b1_red", 64'(redirect), 64'h1);

    // Reset in the cycle of a taken branch
    rst_n = 1'b0;
    br(1'b1, 1'b1, 64'h300, 64'h8);
    cyc("rst_mid"); chk("rst_mid_pc", pc, 64'h0); chk("rst_mid_red", 64'(redirect), 64'h0);
    chk("rst_mid_cnt", 64'(taken_cnt), 64'h0);
    rst_n = 1'b1;
    br(1'b0, 1'b0, 64'h0, 64'h0);
    cyc("boot2");

    // Misaligned target from pc=0x100
    br(1'b1, 1'b1, 64'h100, 64'h0);
    cyc("mis_pre");
    br(1'b1, 1'b1, 64'h100, 64'h2);
    cyc("mis");
    br(1'b0, 1'b0, 64'h0, 64'h0);
    fetch_ready = 1'b0;
    cyc("mis_after");
    chk("mis_pc", pc, ALIGN_EN ? 64'h100 : 64'h102);
    chk("mis_flag", 64'(misalign), ALIGN_EN ? 64'h1 : 64'h0);
    chk("mis_valid", 64'(pc_valid), ALIGN_EN ? 64'h0 : 64'h1);
    fetch_ready = 1'b1;
    cyc("mis_hold");

    // Random traffic with occasional resets
    rst_n = 1'b0;
    cyc("rnd_rst");
    for (int i = 0; i < 400; i++) begin
      rst_n         = ($urandom_range(0, 39) != 0);
      fetch_ready   = ($urandom_range(0, 3) != 0);
      stall         = ($urandom_range(0, 4) == 0);
      branch_valid  = ($urandom_range(0, 2) == 0);
      branch_taken  = $urandom_range(0, 1) == 1;
      branch_pc     = {$urandom(), $urandom()};
      if ($urandom_range(0, 7) == 0)
        branch_off_sh = {$urandom(), $urandom()};
      else
        branch_off_sh = {{32{1'b0}}, $urandom()} & 64'hFFFF_FFFC;
      if ($urandom_range(0, 7) != 0) branch_pc[1:0] = 2'b00;
      cyc("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_next_unit.md
PC_NEXT_UNIT -- requirements
Module: pc_next_unit

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 64'h0, giving the PC value loaded on reset.
REQ-002 The module SHALL have parameter INSTR_BYTES, default 4, giving the sequential PC increment.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 Port branch_valid, input, 1 bit: branch/jump resolution from the execute stage is present this cycle.
REQ-006 Port branch_taken, input, 1 bit: the resolved branch is taken; ignored when branch_valid=0.
REQ-007 Port branch_pc, input, 64 bits: PC of the resolving branch instruction.
REQ-008 Port branch_off_sh, input, 64 bits: sign-extended offset already shifted left by 1, produced by the upstream shift-left-by-1 stage.
REQ-009 Port fetch_ready, input, 1 bit: instruction memory accepts the presented PC.
REQ-010 Port stall, input, 1 bit: pipeline hazard; blocks sequential advance.
REQ-011 Port pc, output, 64 bits: current fetch address.
REQ-012 Port pc_valid, output, 1 bit: pc is a valid fetch request.
REQ-013 Port redirect, output, 1 bit: one-cycle pulse marking that pc was just loaded from a branch target; downstream uses it to flush.
REQ-014 Port taken_cnt, output, 32 bits: saturating count of accepted taken redirects.
REQ-015 Port misalign, output, 1 bit: sticky misaligned-target flag (see Configuration).

Function
REQ-016 The module SHALL implement the states BOOT, RUN and HALT.
REQ-017 BOOT: pc=RESET_PC, pc_valid=0; the module SHALL move to RUN unconditionally after one cycle.
REQ-018 RUN: pc_valid=1.
REQ-019 target SHALL be branch_pc + branch_off_sh, computed modulo 2^64 with the carry discarded; negative offsets wrap correctly.
REQ-020 A redirect event SHALL occur when the state is RUN, branch_valid=1 and branch_taken=1.
REQ-021 On a redirect event, pc SHALL become target on the next edge, with redirect=1 for exactly that following cycle.
REQ-022 The redirect-event load of REQ-021 SHALL happen regardless of stall and fetch_ready.
REQ-023 An accept event SHALL occur when pc_valid=1, fetch_ready=1 and stall=0.
REQ-024 When an accept event occurs and there is no redirect event, pc SHALL become pc+INSTR_BYTES (mod 2^64), so 64'hFFFF_FFFF_FFFF_FFFC wraps to 0.
REQ-025 In all other RUN cycles, pc SHALL hold its value; pc SHALL stay stable while pc_valid=1 and fetch_ready=0 unless a redirect event occurs.
REQ-026 A redirect event SHALL take priority over an accept event in the same cycle; the sequential increment is discarded.
REQ-027 A redirect event in BOOT SHALL be ignored.
REQ-028 Back-to-back redirect events SHALL each load their own target, with redirect held high for consecutive cycles.
REQ-029 taken_cnt SHALL increment by 1 on each redirect event and saturate at 32'hFFFF_FFFF.
REQ-030 Latency from the redirect event to target appearing on pc SHALL be 1 cycle.
REQ-031 Latency from the accept event to the next pc SHALL be 1 cycle.

Reset
REQ-032 When rst_n=0 at a rising edge, the module SHALL enter BOOT and set pc=RESET_PC, pc_valid=0, redirect=0, taken_cnt=0 and misalign=0.
REQ-033 Reset SHALL override every other input, including a redirect event mid-operation; no event in the reset cycle SHALL take effect.
REQ-034 HALT SHALL be exited only by reset.

Configuration
REQ-035 When macro PC_ALIGN_CHECK_EN is defined and target[1:0]!=2'b00 on a redirect event, the module SHALL leave pc unchanged and keep redirect=0.
REQ-036 In the misaligned case of REQ-035, the module SHALL set misalign=1 and enter HALT with pc_valid=0.
REQ-037 In the misaligned case of REQ-035, taken_cnt SHALL NOT increment.
REQ-038 When PC_ALIGN_CHECK_EN is undefined, misalign SHALL be tied 0, HALT SHALL be unreachable, and any target SHALL be loaded unchanged.

Verification
REQ-039 Sequential fetch: release reset, fetch_ready=1, stall=0 -> pc=0 with pc_valid=0 for 1 cycle, then pc_valid=1 and pc steps 0, 4, 8, 12.
REQ-040 Backpressure: pc=8 with fetch_ready=0 for 3 cycles, then 1 -> pc holds 8 for 3 cycles, then becomes 12; stall=1 gives the same hold.
REQ-041 Taken branch: branch_pc=64'h100, branch_off_sh=64'h40, taken, with an accept in the same cycle -> next cycle pc=64'h140, redirect=1 for 1 cycle, taken_cnt=1.
REQ-042 Backward branch: branch_pc=64'h200, branch_off_sh=64'hFFFF_FFFF_FFFF_FFF0 -> pc=64'h1F0; not-taken resolution (branch_taken=0) -> sequential advance continues, taken_cnt unchanged.
REQ-043 Misaligned target with PC_ALIGN_CHECK_EN defined: branch_pc=64'h100, branch_off_sh=64'h2 -> pc stays 64'h100, misalign=1, pc_valid=0 until rst_n=0; without the macro -> pc=64'h102, misalign=0.
REQ-044 Reset mid-redirect: rst_n=0 in the cycle of a taken branch -> pc=RESET_PC, redirect=0, taken_cnt=0.
